// File: rtl/instr_encoder.sv
// RV64 instruction encoder: turns one {kind, funct, regs, imm} request into its 32-bit word(s).
// LI expands to LUI+ADDI; a single output register stage with valid/ready on both sides.
module instr_encoder #(
  parameter int unsigned XLEN      = 64,
  parameter bit          CHECK_IMM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_kind,
  input  logic [2:0]  in_func3,
  input  logic [6:0]  in_func7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        err_illegal
);

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcRw     = 7'b0111011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcImmW   = 7'b0011011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [31:0] ShamtMax = 32'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StOut, StOutHi} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pend_q, pend_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [31:0] word0, word1;
  logic [19:0] li_hi;
  logic [11:0] i_imm;
  logic        two_words, imm_bad, kind_bad, req_err;
  logic        fits_i, fits_b, fits_j, is_shift, accept;

  // Request encoder: pure function of the input fields.
  always_comb begin
    fits_i = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
    fits_b = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
    fits_j = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574)
             && !in_imm[0];
    is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);
    // Rounded upper part: adding 0x800 carries into bit 12 exactly when imm[11] is set.
    li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
    i_imm = in_imm[11:0];
    word0 = '0;
    word1 = '0;
    two_words = 1'b0;
    imm_bad = 1'b0;
    kind_bad = 1'b0;
    case (in_kind)
      4'd0: word0 = {in_func7, in_rs2, in_rs1, in_func3, in_rd, OpcR};
      4'd1: word0 = {in_func7, in_rs2, in_rs1, in_func3, in_rd, OpcRw};
      4'd2, 4'd3: begin
        if (is_shift) begin
          if (in_kind == 4'd2) begin
            i_imm = {1'b0, in_func7[5], 4'b0, in_imm[5:0]};
            imm_bad = in_imm > ShamtMax;
          end else begin
            i_imm = {1'b0, in_func7[5], 5'b0, in_imm[4:0]};
            imm_bad = in_imm > 32'd31;
          end
        end else begin
          imm_bad = !fits_i;
        end
        word0 = {i_imm, in_rs1, in_func3, in_rd, (in_kind == 4'd2) ? OpcImm : OpcImmW};
      end
      4'd4: begin
        imm_bad = !fits_i;
        word0 = {in_imm[11:0], in_rs1, in_func3, in_rd, OpcLoad};
      end
      4'd5: begin
        imm_bad = !fits_i;
        word0 = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], OpcStore};
      end
      4'd6: begin
        imm_bad = !fits_b;
        word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3, in_imm[4:1], in_imm[11],
                 OpcBranch};
      end
      4'd7: begin
        imm_bad = !fits_j;
        word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpcJal};
      end
      4'd8: begin
        imm_bad = !fits_i;
        word0 = {in_imm[11:0], in_rs1, in_func3, in_rd, OpcJalr};
      end
      4'd9: begin
        imm_bad = |in_imm[11:0];
        word0 = {in_imm[31:12], in_rd, OpcLui};
      end
      4'd10: begin
        imm_bad = |in_imm[11:0];
        word0 = {in_imm[31:12], in_rd, OpcAuipc};
      end
      4'd11: begin
        if (fits_i) begin
          word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OpcImm};
        end else begin
          word0 = {li_hi, in_rd, OpcLui};
          word1 = {in_imm[11:0], in_rd, 3'b000, in_rd, OpcImm};
          two_words = |in_imm[11:0];
        end
      end
      default: kind_bad = 1'b1;
    endcase
    req_err = kind_bad || (CHECK_IMM && imm_bad);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      instr_q <= '0;
      pend_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    accept  = in_valid && in_ready;
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    last_d  = last_q;
    err_d   = 1'b0;
    case (state_q)
      StOutHi: begin
        if (out_ready) begin
          instr_d = pend_q;
          last_d  = 1'b1;
          state_d = StOut;
        end
      end
      default: begin
        if (state_q == StOut && out_ready) state_d = StIdle;
        if (accept) begin
          if (req_err) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            instr_d = word0;
            pend_d  = word1;
            last_d  = !two_words;
            state_d = two_words ? StOutHi : StOut;
          end
        end
      end
    endcase
  end

  always_comb begin
    in_ready    = (state_q == StIdle) || (state_q == StOut && out_ready);
    out_valid   = (state_q != StIdle);
    out_instr   = instr_q;
    out_last    = last_q;
    err_illegal = err_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings plus random traffic checked against a
// queue-based reference model built from the RISC-V field layouts.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err_illegal;

  always #5 clk = ~clk;

  instr_encoder #(.XLEN(64), .CHECK_IMM(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_func3   (in_func3),
    .in_func7   (in_func7),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .err_illegal(err_illegal)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        last;
  } ent_t;

  ent_t mq[$];
  bit   err_exp;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits(input logic [31:0] v, input int hi, input int lo);
    return 32'((64'(v) >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1));
  endfunction

  // Reference: arithmetic field placement straight from the instruction formats.
  function automatic void model(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output int n, output logic [31:0] w0, output logic [31:0] w1,
                                output bit bad);
    longint s;
    logic [31:0] F3, F7, RD, RS1, RS2, opc, immf, lim, hi, lo;
    bit i_ok, shift;
    s = longint'($signed(imm));
    F3 = 32'(f3); F7 = 32'(f7); RD = 32'(rd); RS1 = 32'(rs1); RS2 = 32'(rs2);
    i_ok = (s >= -2048) && (s <= 2047);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    bad = 1'b0; n = 1; w0 = '0; w1 = '0; opc = '0;
    case (k)
      4'd0, 4'd1: begin
        opc = (k == 4'd0) ? 32'h33 : 32'h3B;
        w0 = (F7 << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | opc;
      end
      4'd2, 4'd3, 4'd4, 4'd8: begin
        case (k)
          4'd2: opc = 32'h13;
          4'd3: opc = 32'h1B;
          4'd4: opc = 32'h03;
          default: opc = 32'h67;
        endcase
        if ((k == 4'd2 || k == 4'd3) && shift) begin
          lim = (k == 4'd2) ? 32'd63 : 32'd31;
          bad = imm > lim;
          immf = bits(F7, 5, 5) * 1024 + (imm & lim);
        end else begin
          bad = !i_ok;
          immf = imm & 32'hFFF;
        end
        w0 = (immf << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | opc;
      end
      4'd5: begin
        bad = !i_ok;
        w0 = (bits(imm, 11, 5) << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12)
             | (bits(imm, 4, 0) << 7) | 32'h23;
      end
      4'd6: begin
        bad = (s < -4096) || (s > 4094) || imm[0];
        w0 = (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | (RS2 << 20) | (RS1 << 15)
             | (F3 << 12) | (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7) | 32'h63;
      end
      4'd7: begin
        bad = (s < -1048576) || (s > 1048574) || imm[0];
        w0 = (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20)
             | (bits(imm, 19, 12) << 12) | (RD << 7) | 32'h6F;
      end
      4'd9, 4'd10: begin
        bad = (imm & 32'hFFF) != 0;
        w0 = (imm & 32'hFFFFF000) | (RD << 7) | ((k == 4'd9) ? 32'h37 : 32'h17);
      end
      4'd11: begin
        if (i_ok) begin
          w0 = ((imm & 32'hFFF) << 20) | (RD << 7) | 32'h13;
        end else begin
          hi = (imm + 32'h800) >> 12;
          lo = imm - (hi << 12);
          w0 = (hi << 12) | (RD << 7) | 32'h37;
          if (lo != 0) begin
            n = 2;
            w1 = ((lo & 32'hFFF) << 20) | (RD << 15) | (RD << 7) | 32'h13;
          end
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) n = 0;
  endfunction

  // One clock: check outputs at the negedge, then advance the model across the posedge.
  task automatic cycle();
    int n;
    logic [31:0] w0, w1;
    bit bad, exp_ready, acc, cons;
    @(negedge clk);
    exp_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready);
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_instr", out_instr, mq[0].w);
      chk("out_last", 32'(out_last), 32'(mq[0].last));
    end
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("err_illegal", 32'(err_illegal), 32'(err_exp));
    acc = in_valid && exp_ready;
    cons = (mq.size() != 0) && out_ready;
    model(in_kind, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, n, w0, w1, bad);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      err_exp = 1'b0;
    end else begin
      if (cons) void'(mq.pop_front());
      err_exp = acc && bad;
      if (acc && n == 1) mq.push_back('{w: w0, last: 1'b1});
      if (acc && n == 2) begin
        mq.push_back('{w: w0, last: 1'b0});
        mq.push_back('{w: w1, last: 1'b1});
      end
    end
    #1;
  endtask

  task automatic set_req(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    in_valid = 1'b1; in_kind = k; in_func3 = f3; in_func7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  function automatic logic [31:0] rand_imm();
    int edges[18] = '{-2048, 2047, -2049, 2048, -4096, 4094, 4095, -4098, 1048574, -1048576,
                      1048576, 63, 64, 31, 32, 0, 32'h800, 32'h3000};
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 127)) - 32'd64;
      1: return 32'(edges[$urandom_range(0, 17)]);
      2: return $urandom;
      3: return $urandom & 32'hFFFFF000;
      4: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      default: return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_func3 = '0; in_func7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; err_exp = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);

    reset = 1'b0; out_ready = 1'b1;
    set_req(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    cycle();
    chk("add_word", out_instr, 32'h002081B3);
    chk("add_last", 32'(out_last), 32'd1);
    chk("add_valid", 32'(out_valid), 32'd1);

    set_req(4'd11, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    cycle();
    in_valid = 1'b0;
    chk("li_lui", out_instr, 32'h123452B7);
    chk("li_lui_last", 32'(out_last), 32'd0);
    chk("li_hold_ready", 32'(in_ready), 32'd0);
    cycle();
    chk("li_addi", out_instr, 32'h67828293);
    chk("li_addi_last", 32'(out_last), 32'd1);

    set_req(4'd11, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    cycle();
    in_valid = 1'b0;
    chk("li800_lui", out_instr, 32'h000010B7);
    cycle();
    chk("li800_addi", out_instr, 32'h80008093);
    set_req(4'd11, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h3000);
    cycle();
    chk("li3000_lui", out_instr, 32'h000030B7);
    chk("li3000_last", 32'(out_last), 32'd1);

    set_req(4'd6, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd16);
    cycle();
    chk("beq_word", out_instr, 32'h00208863);
    set_req(4'd6, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    cycle();
    in_valid = 1'b0;
    chk("beq_odd_err", 32'(err_illegal), 32'd1);
    chk("beq_odd_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("err_pulse_end", 32'(err_illegal), 32'd0);

    set_req(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_word", out_instr, 32'h002081B3);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_last", 32'(out_last), 32'd1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(4'd2, 3'd0, 7'd0, 5'(i + 1), 5'd2, 5'd0, 32'(i * 100));
      cycle();
      chk("b2b_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    cycle();

    set_req(4'd11, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    cycle();
    in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_hi_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("rst_hi_no_addi", 32'(out_valid), 32'd0);

    set_req(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    reset = 1'b1;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    chk("rst_accept_lost", 32'(out_valid), 32'd0);
    cycle();

    for (int c = 0; c < 1500; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_kind = 4'($urandom_range(0, 15));
      in_func3 = 3'($urandom);
      in_func7 = 7'($urandom);
      in_rd = 5'($urandom);
      in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom);
      in_imm = rand_imm();
      out_ready = $urandom_range(0, 9) < 7;
      reset = $urandom_range(0, 299) == 0;
      cycle();
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
